// File: rtl/lab1_imul_resp_accum.sv
// -----------------------------------------------------------------------------
// lab1_imul_resp_accum
//
// Multiply-accumulate back end for the integer multiplier. Consumes the
// multiplier's 32-bit product stream over a val/rdy handshake, sums every
// group of p_nterms consecutive products into one 32-bit dot-product term, and
// hands that term (plus a sticky unsigned-carry flag) downstream over a second
// val/rdy handshake.
//
// The block alternates between two phases and never overlaps them:
//   ACCUM : in_rdy=1, out_val=0. Each accepted product is added into r_acc.
//           The p_nterms-th product moves the block to DONE.
//   DONE  : in_rdy=0, out_val=1. r_acc/r_ovf are presented unchanged until
//           the sink takes them, after which everything clears for the next
//           group.
//
// Parameters
//   p_nterms : products per group, legal range 1..256.
//
// Ports
//   clk      in   1   clock, all state updates on the rising edge
//   reset    in   1   synchronous, active-low reset (0 = reset)
//   in_val   in   1   product valid (multiplier response valid)
//   in_rdy   out  1   block can accept a product
//   in_msg   in   32  product (multiplier response result)
//   out_val  out  1   group sum valid
//   out_rdy  in   1   downstream ready
//   out_msg  out  32  group sum modulo 2^32
//   out_ovf  out  1   some unsigned add in the group carried out of bit 31
// -----------------------------------------------------------------------------
module lab1_imul_resp_accum #(
  parameter int p_nterms = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_val,
  output logic        in_rdy,
  input  logic [31:0] in_msg,

  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_msg,
  output logic        out_ovf
);

  // ---------------------------------------------------------------------------
  // Local parameters
  // ---------------------------------------------------------------------------
  // The counter must be able to hold p_nterms itself (the value it would take
  // after the last add), hence clog2(p_nterms+1); never narrower than one bit.
  localparam int CntW = ($clog2(p_nterms + 1) < 1) ? 1 : $clog2(p_nterms + 1);

  // Count value seen while the final product of a group is being accepted.
  localparam logic [CntW-1:0] LastCnt = CntW'(p_nterms - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers and their next-state values
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic [CntW-1:0]   r_cnt;
  logic [CntW-1:0]   w_cnt_next;
  logic [31:0]       r_acc;
  logic [31:0]       w_acc_next;
  logic              r_ovf;
  logic              w_ovf_next;

  // Handshake strobes and the 33-bit adder result.
  logic              w_in_go;
  logic              w_out_go;
  logic [32:0]       w_sum;
  logic              w_last_term;

  // ---------------------------------------------------------------------------
  // Handshake signals
  // ---------------------------------------------------------------------------
  // in_rdy and out_val are a function of state and reset only, so there is no
  // combinational path from the producer's in_val or the sink's out_rdy back
  // to either interface. Gating with reset keeps both low for the whole time
  // reset is held, including the very first cycle before the state register
  // has been cleared.
  always_comb begin
    in_rdy  = reset && (r_state == ST_ACCUM);
    out_val = reset && (r_state == ST_DONE);
  end

  assign w_in_go  = in_val  && in_rdy;
  assign w_out_go = out_val && out_rdy;

  // Output data comes straight from registers.
  assign out_msg = r_acc;
  assign out_ovf = r_ovf;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Zero-extend both operands to 33 bits so bit 32 is the unsigned carry out of
  // bit 31. The low 32 bits are the two's-complement wrap, so signed products
  // still sum correctly modulo 2^32; the carry is an unsigned indication only.
  assign w_sum       = {1'b0, r_acc} + {1'b0, in_msg};
  assign w_last_term = (r_cnt == LastCnt);

  // ---------------------------------------------------------------------------
  // Next-state / next-data logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a hold value first, so no
    // path through the case statement can leave one unassigned and infer a
    // latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_acc_next   = r_acc;
    w_ovf_next   = r_ovf;

    unique case (r_state)
      ST_ACCUM: begin
        if (w_in_go) begin
          w_acc_next = w_sum[31:0];
          // Sticky: once any add in the group carries, the flag stays set
          // until the group is handed off.
          w_ovf_next = r_ovf | w_sum[32];
          w_cnt_next = r_cnt + CntOne;
          if (w_last_term) begin
            w_state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Hold the finished sum stable until the sink takes it, then clear
        // for the next group. in_rdy is low here, so no product can be
        // accepted in the same cycle as the hand-off.
        if (w_out_go) begin
          w_acc_next   = '0;
          w_ovf_next   = 1'b0;
          w_cnt_next   = '0;
          w_state_next = ST_ACCUM;
        end
      end

      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled only on the clock edge (it is not in the
  // sensitivity list), which gives a synchronous reset; a partial group or a
  // pending, not-yet-taken sum is simply discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of its inputs.
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
    end
  end

endmodule

// File: tb/tb_lab1_imul_resp_accum.sv
// -----------------------------------------------------------------------------
// tb_lab1_imul_resp_accum
//
// Three instances of the accumulator (p_nterms = 4, 2, 1) share a clock and a
// reset. Directed groups from the test plan are followed by a randomized phase
// with random input bubbles, random products and random sink backpressure.
//
// Reference model: for each instance the bench keeps the number of products
// accepted so far in the current group and their exact 64-bit total. When a
// group completes, the expected output is total mod 2^32, and the carry flag
// is set exactly when the exact total reaches 2^32 (a 32-bit running sum that
// starts at zero carries out at least once iff the true total exceeds 32
// bits). Expected results go into a scoreboard queue; a monitor on the
// falling edge compares whatever the DUT presents against the queue.
// -----------------------------------------------------------------------------
module tb_lab1_imul_resp_accum;

  localparam int NDUT = 3;
  localparam int NT [NDUT] = '{4, 2, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val  [NDUT];
  logic        in_rdy  [NDUT];
  logic [31:0] in_msg  [NDUT];
  logic        out_val [NDUT];
  logic        out_rdy [NDUT];
  logic [31:0] out_msg [NDUT];
  logic        out_ovf [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    lab1_imul_resp_accum #(
      .p_nterms((g == 0) ? 4 : (g == 1) ? 2 : 1)
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .in_val  (in_val[g]),
      .in_rdy  (in_rdy[g]),
      .in_msg  (in_msg[g]),
      .out_val (out_val[g]),
      .out_rdy (out_rdy[g]),
      .out_msg (out_msg[g]),
      .out_ovf (out_ovf[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    int          dut;
    logic [31:0] sum;
    logic        ovf;
  } exp_t;

  exp_t            exp_q [$];
  longint unsigned pend_sum [NDUT];
  int              pend_n   [NDUT];
  logic [31:0]     got_msg  [NDUT];
  logic            got_ovf  [NDUT];
  int              got_n    [NDUT];
  bit              rst_seen;
  bit              rnd_rdy;
  int              n_checks;
  int              n_errors;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic int find_exp(input int k);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].dut == k) return i;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / model: samples on the falling edge, i.e. the values that the
  // next rising edge will act on.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      int   idx;
      exp_t e;
      if (rst_seen) begin
        check($sformatf("dut%0d out_msg after reset", k), out_msg[k], 0);
        check($sformatf("dut%0d out_ovf after reset", k), out_ovf[k], 0);
      end
      if (!reset) begin
        check($sformatf("dut%0d in_rdy in reset", k), in_rdy[k], 0);
        check($sformatf("dut%0d out_val in reset", k), out_val[k], 0);
      end else begin
        idx = find_exp(k);
        check($sformatf("dut%0d out_val", k), out_val[k], (idx >= 0));
        check($sformatf("dut%0d in_rdy", k), in_rdy[k], (idx < 0));
        if (idx >= 0) begin
          e = exp_q[idx];
          check($sformatf("dut%0d out_msg", k), out_msg[k], e.sum);
          check($sformatf("dut%0d out_ovf", k), out_ovf[k], e.ovf);
          if (out_rdy[k]) begin
            exp_q.delete(idx);
            got_msg[k] = out_msg[k];
            got_ovf[k] = out_ovf[k];
            got_n[k]++;
          end
        end else if (in_val[k]) begin
          pend_sum[k] += 64'(in_msg[k]);
          pend_n[k]++;
          if (pend_n[k] == NT[k]) begin
            e.dut = k;
            e.sum = pend_sum[k][31:0];
            e.ovf = (pend_sum[k] >> 32) != 0;
            exp_q.push_back(e);
            pend_sum[k] = 0;
            pend_n[k]   = 0;
          end
        end
      end
    end
    // The coming rising edge resets every instance: partial and pending
    // groups vanish.
    if (!reset) begin
      exp_q.delete();
      for (int k = 0; k < NDUT; k++) begin
        pend_sum[k] = 0;
        pend_n[k]   = 0;
      end
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input int k, input logic [31:0] msg);
    int budget;
    bit ok;
    budget    = 0;
    ok        = 1'b0;
    in_val[k] = 1'b1;
    in_msg[k] = msg;
    while (!ok) begin
      @(negedge clk);
      ok = in_rdy[k];
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy[k] = 1'($urandom_range(0, 1));
      budget++;
      if (!ok && budget > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut%0d send timeout: got in_rdy=0 for 200 cycles, expected 1", k);
        ok = 1'b1;
      end
    end
    in_val[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    out_rdy[k] = 1'b1;
    idle(k, 4);
  endtask

  task automatic expect_group(input int k, input int n0, input logic [31:0] m,
                              input logic o);
    drain(k);
    check($sformatf("dut%0d group count", k), got_n[k], n0 + 1);
    check($sformatf("dut%0d group msg", k), got_msg[k], m);
    check($sformatf("dut%0d group ovf", k), got_ovf[k], o);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_prod();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 255));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: return 32'h8000_0000 | $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    n_checks = 0;
    n_errors = 0;
    rnd_rdy  = 1'b0;
    rst_seen = 1'b0;
    reset    = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      in_val[k]   = 1'b0;
      in_msg[k]   = '0;
      out_rdy[k]  = 1'b1;
      pend_sum[k] = 0;
      pend_n[k]   = 0;
      got_msg[k]  = '0;
      got_ovf[k]  = 1'b0;
      got_n[k]    = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic group, p_nterms=4.
    n0 = got_n[0];
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    expect_group(0, n0, 32'h0000_000A, 1'b0);

    // Wrap/carry, p_nterms=2, then the flag clears for the next group.
    n0 = got_n[1];
    send(1, 32'hFFFF_FFFF); send(1, 32'h0000_0002);
    expect_group(1, n0, 32'h0000_0001, 1'b1);
    n0 = got_n[1];
    send(1, 5); send(1, 6);
    expect_group(1, n0, 32'h0000_000B, 1'b0);

    // Signed sum, p_nterms=2.
    n0 = got_n[1];
    send(1, 32'hFFFF_FFFD); send(1, 32'h0000_0007);
    expect_group(1, n0, 32'h0000_0004, 1'b1);

    // Backpressure: 5 cycles of out_rdy=0 with the next group waiting.
    n0 = got_n[0];
    out_rdy[0] = 1'b0;
    send(0, 10); send(0, 20); send(0, 30); send(0, 40);
    fork
      begin
        send(0, 1); send(0, 1); send(0, 1); send(0, 1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_rdy[0] = 1'b1;
        @(negedge clk);
        #1;
        check("dut0 held group count", got_n[0], n0 + 1);
        check("dut0 held group msg", got_msg[0], 32'h0000_0064);
      end
    join
    expect_group(0, n0 + 1, 32'h0000_0004, 1'b0);

    // Input bubbles, p_nterms=4.
    n0 = got_n[0];
    idle(0, $urandom_range(1, 3)); send(0, 7);
    idle(0, $urandom_range(1, 3)); send(0, 0);
    idle(0, $urandom_range(1, 3)); send(0, 9);
    idle(0, $urandom_range(1, 3)); send(0, 1);
    expect_group(0, n0, 32'h0000_0011, 1'b0);

    // p_nterms=1: output equals the single product.
    n0 = got_n[2];
    send(2, 32'h1234_5678);
    expect_group(2, n0, 32'h1234_5678, 1'b0);

    // Reset mid-group: 100+200 is dropped; a product offered during reset is
    // not taken.
    n0 = got_n[0];
    send(0, 100); send(0, 200);
    in_val[0] = 1'b1;
    in_msg[0] = 32'd999;
    reset_pulse();
    in_val[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    expect_group(0, n0, 32'h0000_000A, 1'b0);

    // Reset while a finished sum is waiting in DONE.
    n0 = got_n[0];
    out_rdy[0] = 1'b0;
    send(0, 5); send(0, 6); send(0, 7); send(0, 8);
    idle(0, 2);
    reset_pulse();
    out_rdy[0] = 1'b1;
    idle(0, 2);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    expect_group(0, n0, 32'h0000_000A, 1'b0);

    // Randomized phase: random products, bubbles and sink backpressure.
    for (int k = 0; k < NDUT; k++) begin
      rnd_rdy = 1'b1;
      for (int g = 0; g < 8; g++) begin
        for (int t = 0; t < NT[k]; t++) begin
          idle(k, $urandom_range(0, 2));
          send(k, rand_prod());
        end
      end
      rnd_rdy = 1'b0;
      drain(k);
    end

    check("scoreboard empty at end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
